// File: rtl/wb_scoreboard_pkg.sv
// rtl/wb_scoreboard_pkg.sv - shared core constants and types for writeback and register file
package wb_scoreboard_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Which result channel won the writeback slot this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LD   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard_busy_table.sv
// rtl/wb_scoreboard_busy_table.sv - pending-write busy vector with set/clear/query
module busy_table
  import wb_scoreboard_pkg::REG_IDX_W;
#(
  parameter int NREG = wb_scoreboard_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Clear first so a same-index issue on the write edge keeps the register busy; x0 never busy
  always_comb begin
    busy_nxt = busy;
    if (clr_en) begin
      busy_nxt[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != '0)) begin
      busy_nxt[set_idx] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs1_busy = (rs1_addr != '0) && busy[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) && busy[rs2_addr];

endmodule

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - writeback arbiter, registered RF write port and busy scoreboard
module wb_scoreboard
  import wb_scoreboard_pkg::REG_IDX_W,
         wb_scoreboard_pkg::wb_src_e,
         wb_scoreboard_pkg::SRC_NONE,
         wb_scoreboard_pkg::SRC_ALU,
         wb_scoreboard_pkg::SRC_LD;
#(
  parameter int XLEN = wb_scoreboard_pkg::XLEN,
  parameter int NREG = wb_scoreboard_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] rd_addr,
  output logic [XLEN-1:0]      write_data
);

  wb_src_e src;
  logic    ld_acc;
  logic    alu_acc;

  // Loads always win; both channels are held off while reset is asserted
  assign ld_ready  = rst_n;
  assign alu_ready = rst_n & ~ld_valid;
  assign ld_acc    = ld_valid & ld_ready;
  assign alu_acc   = alu_valid & alu_ready;

  // Pick the channel that owns the writeback slot on the coming edge
  always_comb begin
    src = SRC_NONE;
    if (ld_acc) begin
      src = SRC_LD;
    end else if (alu_acc) begin
      src = SRC_ALU;
    end
  end

  // Registered write port; x0 results are consumed without asserting the write enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      rd_addr    <= '0;
      write_data <= '0;
    end else begin
      case (src)
        SRC_LD: begin
          RegWrite   <= (ld_rd != '0);
          rd_addr    <= ld_rd;
          write_data <= ld_data;
        end
        SRC_ALU: begin
          RegWrite   <= (alu_rd != '0);
          rd_addr    <= alu_rd;
          write_data <= alu_data;
        end
        default: begin
          RegWrite <= 1'b0;
        end
      endcase
    end
  end

  busy_table #(
    .NREG(NREG)
  ) u_busy_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_valid),
    .set_idx  (issue_rd),
    .clr_en   (RegWrite),
    .clr_idx  (rd_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb/tb_wb_scoreboard.sv - self-checking bench for wb_scoreboard against a behavioural model
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        RegWrite;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: set of registers with outstanding writes, and the last write-port contents
  bit          pend [32];
  bit          m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;

  wb_scoreboard #(.XLEN(32), .NREG(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .RegWrite    (RegWrite),
    .rd_addr     (rd_addr),
    .write_data  (write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending-write set plus a one-deep writeback slot
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (pend[i]) pend[i] = 1'b0;
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
    end else begin
      bit          took;
      logic [4:0]  t_rd;
      logic [31:0] t_data;
      took = 1'b0;
      t_rd = '0;
      t_data = '0;
      if (ld_valid) begin
        took = 1'b1; t_rd = ld_rd; t_data = ld_data;
      end else if (alu_valid) begin
        took = 1'b1; t_rd = alu_rd; t_data = alu_data;
      end
      if (m_we) pend[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
      m_we = took && (t_rd != 0);
      if (took) begin
        m_rd = t_rd;
        m_data = t_data;
      end
    end
  end

  // Compare every output against the model each cycle
  always @(negedge clk) begin
    check("cmp_regwrite", {31'd0, RegWrite}, {31'd0, m_we});
    check("cmp_rd_addr", {27'd0, rd_addr}, {27'd0, m_rd});
    check("cmp_write_data", write_data, m_data);
    check("cmp_rs1_busy", {31'd0, rs1_busy}, {31'd0, pend[rs1_addr]});
    check("cmp_rs2_busy", {31'd0, rs2_busy}, {31'd0, pend[rs2_addr]});
    check("cmp_alu_ready", {31'd0, alu_ready}, {31'd0, rst_n && !ld_valid});
    check("cmp_ld_ready", {31'd0, ld_ready}, {31'd0, rst_n});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    alu_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  initial begin
    bit stall;
    // Reset state
    #2;
    check("reset_regwrite", {31'd0, RegWrite}, 32'd0);
    check("reset_write_data", write_data, 32'd0);
    check("reset_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("reset_ld_ready", {31'd0, ld_ready}, 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Issue rd=5, ALU writes 5 one cycle later
    step();
    issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
    step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    check("s1_busy_before", {31'd0, rs1_busy}, 32'd1);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    check("s1_regwrite", {31'd0, RegWrite}, 32'd1);
    check("s1_rd_addr", {27'd0, rd_addr}, 32'd5);
    check("s1_data", write_data, 32'hDEADBEEF);
    check("s1_busy_during", {31'd0, rs1_busy}, 32'd1);
    step();
    @(negedge clk);
    check("s1_busy_after", {31'd0, rs1_busy}, 32'd0);
    check("s1_we_drop", {31'd0, RegWrite}, 32'd0);

    // Load and ALU together: load first, ALU next cycle
    step();
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    @(negedge clk);
    check("s2_alu_stalled", {31'd0, alu_ready}, 32'd0);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    check("s2_first_rd", {27'd0, rd_addr}, 32'd3);
    check("s2_first_data", write_data, 32'h11);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    check("s2_second_we", {31'd0, RegWrite}, 32'd1);
    check("s2_second_rd", {27'd0, rd_addr}, 32'd4);
    check("s2_second_data", write_data, 32'h22);

    // ALU result to x0 is consumed silently
    step();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5; rs1_addr = 5'd0;
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    check("s3_x0_no_write", {31'd0, RegWrite}, 32'd0);
    check("s3_x0_not_busy", {31'd0, rs1_busy}, 32'd0);

    // Issue rd=7 on the edge that writes rd=7: set wins
    step();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77; rs2_addr = 5'd7;
    step();
    ld_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    check("s4_write7", {31'd0, RegWrite}, 32'd1);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    check("s4_set_wins", {31'd0, rs2_busy}, 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
    step();
    ld_valid = 1'b0;
    step();

    // Reset during an acceptance
    issue_valid = 1'b1; issue_rd = 5'd9; rs1_addr = 5'd9;
    step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    #1;
    rst_n = 1'b0;
    #1;
    check("s5_rst_we", {31'd0, RegWrite}, 32'd0);
    check("s5_rst_rd", {27'd0, rd_addr}, 32'd0);
    check("s5_rst_busy", {31'd0, rs1_busy}, 32'd0);
    check("s5_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    alu_valid = 1'b0;
    step();
    // Release with a load waiting: must be taken on the first edge
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h2222;
    @(negedge clk);
    check("s5_no_stale_we", {31'd0, RegWrite}, 32'd0);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    check("s5_first_acc_we", {31'd0, RegWrite}, 32'd1);
    check("s5_first_acc_data", write_data, 32'h2222);

    // Eight back-to-back loads
    step();
    for (int i = 1; i <= 8; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'h1000 * i + i;
      @(negedge clk);
      if (i > 1) begin
        check("s6_we", {31'd0, RegWrite}, 32'd1);
        check("s6_rd", {27'd0, rd_addr}, 32'(i - 1));
        check("s6_data", write_data, 32'h1000 * (i - 1) + (i - 1));
      end
      step();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    check("s6_last_rd", {27'd0, rd_addr}, 32'd8);
    check("s6_last_data", write_data, 32'h8008);
    step();
    idle();

    // Randomized traffic; a stalled ALU result is held by the upstream
    for (int c = 0; c < 3000; c++) begin
      stall = alu_valid && ld_valid;
      step();
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_rd = 5'($urandom_range(0, 7));
      ld_data = $urandom;
      if (!stall) begin
        alu_valid = ($urandom_range(0, 1) == 0);
        alu_rd = 5'($urandom_range(0, 7));
        alu_data = $urandom;
      end
    end
    idle();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
